// File: rtl/abp_sender_transmitter.sv
// ---------------------------------------------------------------------------
// abp_sender_transmitter
//
// Sender side of an alternating-bit protocol link. A 64-bit application value
// is latched and sent as a fixed-length byte frame on an AXI-Stream master:
//   byte 0..7                 : value bytes, least significant byte first
//   byte 8..FRAME_BYTES-2     : zero padding
//   byte FRAME_BYTES-1        : {7'b0, alternating bit}
// After the last byte the block waits for an ACK carrying the same bit. A
// matching ACK completes the transfer and toggles the bit; a timeout resends
// the identical frame from the latched copy.
//
// Optional build feature (macro ABP_SENDER_STATS_EN):
//   adds output retx_count[15:0], the saturating number of timeout-driven
//   retransmits for the current value. It is cleared one cycle after
//   send_done so that its final value is readable during the send_done cycle.
//   With the macro undefined the port and counter do not exist.
// ---------------------------------------------------------------------------
module abp_sender_transmitter #(
    parameter int FRAME_BYTES    = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMER_WIDTH    = 16
) (
    input  logic        aclk,
    input  logic        areset,
    // application side
    input  logic        send_valid,
    output logic        send_ready,
    input  logic [63:0] send_value,
    output logic        send_done,
    output logic        busy,
    output logic        current_bit,
    // byte stream towards the link
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    // acknowledge return path
    input  logic        ack_valid,
    input  logic        ack_bit
`ifdef ABP_SENDER_STATS_EN
    ,
    output logic [15:0] retx_count
`endif
);

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    localparam int                     IDX_W        = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0]       LAST_IDX     = IDX_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0]       IDX_ZERO     = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]       IDX_ONE      = IDX_W'(1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO   = {TIMER_WIDTH{1'b0}};
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE    = TIMER_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX    = {TIMER_WIDTH{1'b1}};
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Frame byte generator: the frame is never stored, each byte is derived
    // from the latched value, the alternating bit and the byte index.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] frame_byte(
        input logic [63:0]      value,
        input logic             abit,
        input logic [IDX_W-1:0] idx
    );
        logic [7:0] byte_v;
        if (idx < IDX_W'(8)) begin
            byte_v = value[{idx[2:0], 3'b000} +: 8];
        end else if (idx == LAST_IDX) begin
            byte_v = {7'b0000000, abit};
        end else begin
            byte_v = 8'h00;
        end
        return byte_v;
    endfunction

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_t                   state_r;
    logic [IDX_W-1:0]         idx_r;
    logic [TIMER_WIDTH-1:0]   timer_r;
    logic [63:0]              value_r;
    logic                     current_bit_r;
    logic                     send_ready_r;
    logic                     send_done_r;
    logic                     busy_r;
    logic                     tvalid_r;
    logic                     tlast_r;
    logic [7:0]               tdata_r;

    // -----------------------------------------------------------------------
    // Decoded events
    // -----------------------------------------------------------------------
    logic                     accept_s;
    logic                     handshake_s;
    logic                     ack_match_s;
    logic                     timeout_s;
    logic [IDX_W-1:0]         next_idx_s;

    // Decode acceptance, stream handshake, matching ACK and timeout expiry.
    always_comb begin
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        ack_match_s = 1'b0;
        timeout_s   = 1'b0;
        next_idx_s  = idx_r + IDX_ONE;
        if (state_r == ST_IDLE) begin
            accept_s = send_valid & send_ready_r;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == ST_SEND) begin
            handshake_s = tvalid_r & m_axis_tready;
        end else begin
            handshake_s = 1'b0;
        end
        if (state_r == ST_WAIT_ACK) begin
            // a matching ACK takes priority over a simultaneous timeout
            ack_match_s = ack_valid & (ack_bit == current_bit_r);
            timeout_s   = ~ack_match_s & (timer_r == TIMEOUT_LAST);
        end else begin
            ack_match_s = 1'b0;
            timeout_s   = 1'b0;
        end
    end

    // Main sender FSM: accept value, stream frame, wait for ACK or timeout.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r       <= ST_IDLE;
            idx_r         <= IDX_ZERO;
            timer_r       <= TIMER_ZERO;
            value_r       <= 64'h0000_0000_0000_0000;
            current_bit_r <= 1'b0;
            send_ready_r  <= 1'b0;
            send_done_r   <= 1'b0;
            busy_r        <= 1'b0;
            tvalid_r      <= 1'b0;
            tlast_r       <= 1'b0;
            tdata_r       <= 8'h00;
        end else begin
            // send_done is a single-cycle pulse
            send_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        value_r      <= send_value;
                        busy_r       <= 1'b1;
                        send_ready_r <= 1'b0;
                        idx_r        <= IDX_ZERO;
                        tvalid_r     <= 1'b1;
                        tdata_r      <= frame_byte(send_value, current_bit_r, IDX_ZERO);
                        tlast_r      <= 1'b0;
                        state_r      <= ST_SEND;
                    end else begin
                        send_ready_r <= 1'b1;
                    end
                end

                ST_SEND: begin
                    if (handshake_s) begin
                        if (idx_r == LAST_IDX) begin
                            tvalid_r <= 1'b0;
                            tlast_r  <= 1'b0;
                            tdata_r  <= 8'h00;
                            idx_r    <= IDX_ZERO;
                            timer_r  <= TIMER_ZERO;
                            state_r  <= ST_WAIT_ACK;
                        end else begin
                            // present the next byte immediately: no bubbles
                            idx_r   <= next_idx_s;
                            tdata_r <= frame_byte(value_r, current_bit_r, next_idx_s);
                            tlast_r <= (next_idx_s == LAST_IDX);
                        end
                    end else begin
                        // stalled: hold tvalid, tdata and tlast
                        idx_r <= idx_r;
                    end
                end

                ST_WAIT_ACK: begin
                    if (ack_match_s) begin
                        send_done_r   <= 1'b1;
                        current_bit_r <= ~current_bit_r;
                        busy_r        <= 1'b0;
                        send_ready_r  <= 1'b1;
                        timer_r       <= TIMER_ZERO;
                        state_r       <= ST_IDLE;
                    end else if (timeout_s) begin
                        // resend the identical frame from the latched value
                        idx_r    <= IDX_ZERO;
                        tvalid_r <= 1'b1;
                        tdata_r  <= frame_byte(value_r, current_bit_r, IDX_ZERO);
                        tlast_r  <= 1'b0;
                        timer_r  <= TIMER_ZERO;
                        state_r  <= ST_SEND;
                    end else if (timer_r != TIMER_MAX) begin
                        // stale or duplicate ACKs fall through here
                        timer_r <= timer_r + TIMER_ONE;
                    end else begin
                        timer_r <= timer_r;
                    end
                end

                default: begin
                    state_r      <= ST_IDLE;
                    idx_r        <= IDX_ZERO;
                    timer_r      <= TIMER_ZERO;
                    send_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    tvalid_r     <= 1'b0;
                    tlast_r      <= 1'b0;
                    tdata_r      <= 8'h00;
                end
            endcase
        end
    end

`ifdef ABP_SENDER_STATS_EN
    logic [15:0] retx_count_r;

    // Retransmit statistics: saturating count, cleared after send_done.
    always_ff @(posedge aclk) begin
        if (areset) begin
            retx_count_r <= 16'h0000;
        end else if (send_done_r) begin
            retx_count_r <= 16'h0000;
        end else if (timeout_s && (retx_count_r != 16'hFFFF)) begin
            retx_count_r <= retx_count_r + 16'h0001;
        end else begin
            retx_count_r <= retx_count_r;
        end
    end

    assign retx_count = retx_count_r;
`endif

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign send_ready    = send_ready_r;
    assign send_done     = send_done_r;
    assign busy          = busy_r;
    assign current_bit   = current_bit_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tdata  = tdata_r;

endmodule

// File: tb/tb_abp_sender_transmitter.sv
// ---------------------------------------------------------------------------
// Testbench for abp_sender_transmitter (FRAME_BYTES=64, TIMEOUT_CYCLES=16).
// Expected frame bytes are pushed to a queue when a value is offered and
// popped by a negedge monitor on every stream handshake. Scenario tasks check
// latency, ACK handling, timeout, collision and reset behaviour inline.
// ---------------------------------------------------------------------------
module tb_abp_sender_transmitter;

    localparam int FB = 64;
    localparam int TO = 16;
    localparam int TW = 16;

    logic        aclk = 1'b0;
    logic        areset;
    logic        send_valid;
    logic        send_ready;
    logic [63:0] send_value;
    logic        send_done;
    logic        busy;
    logic        current_bit;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        ack_valid;
    logic        ack_bit;
`ifdef ABP_SENDER_STATS_EN
    logic [15:0] retx_count;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_mon;
    int         checks   = 0;
    int         errors   = 0;
    int         hs_cnt   = 0;
    int         last_cnt = 0;
    logic       model_bit = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    abp_sender_transmitter #(
        .FRAME_BYTES   (FB),
        .TIMEOUT_CYCLES(TO),
        .TIMER_WIDTH   (TW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .send_valid   (send_valid),
        .send_ready   (send_ready),
        .send_value   (send_value),
        .send_done    (send_done),
        .busy         (busy),
        .current_bit  (current_bit),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .ack_valid    (ack_valid),
        .ack_bit      (ack_bit)
`ifdef ABP_SENDER_STATS_EN
        ,
        .retx_count   (retx_count)
`endif
    );

    always #5 aclk = ~aclk;

    // Scoreboard monitor: stall stability and byte-by-byte frame comparison.
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                hs_cnt++;
                if (m_axis_tlast === 1'b1) last_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data=%h last=%b expected no byte", m_axis_tdata, m_axis_tlast);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (m_axis_tdata !== e_mon.data || m_axis_tlast !== e_mon.last) begin
                        errors++;
                        $display("FAIL sb_byte: got data=%h last=%b expected data=%h last=%b",
                                 m_axis_tdata, m_axis_tlast, e_mon.data, e_mon.last);
                    end
                end
            end
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic push_frame(input logic [63:0] v, input logic b);
        exp_t e;
        for (int k = 0; k < FB; k++) begin
            e.data = (k < 8) ? 8'(v >> (8 * k)) : 8'h00;
            if (k == FB - 1) e.data = {7'b0000000, b};
            e.last = (k == FB - 1);
            exp_q.push_back(e);
        end
    endtask

    // Offers a value for one cycle and scrambles send_value afterwards.
    task automatic start_send(input logic [63:0] v);
        send_value = v;
        send_valid = 1'b1;
        push_frame(v, model_bit);
        tick;
        send_valid = 1'b0;
        send_value = ~v;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        tick;
        tick;
        checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", send_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata); end
        checks++; if (current_bit !== 1'b0) begin errors++; $display("FAIL reset_bit: got %b expected 0", current_bit); end
        checks++; if (send_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", send_done); end
`ifdef ABP_SENDER_STATS_EN
        checks++; if (retx_count !== 16'h0000) begin errors++; $display("FAIL reset_retx: got %h expected 0000", retx_count); end
`endif
        areset = 1'b0;
        tick;
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", send_ready); end
    endtask

    task automatic test_basic;
        m_axis_tready = 1'b1;
        hs_cnt = 0;
        last_cnt = 0;
        start_send(64'h0123_4567_89AB_CDEF);
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hEF) begin errors++; $display("FAIL basic_first: got valid=%b data=%h expected valid=1 data=ef", m_axis_tvalid, m_axis_tdata); end
        checks++; if (busy !== 1'b1 || send_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: got busy=%b ready=%b expected 1 0", busy, send_ready); end
        repeat (63) tick;
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tdata !== 8'h00) begin errors++; $display("FAIL basic_lastbyte: got valid=%b last=%b data=%h expected 1 1 00", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
        tick;
        checks++; if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL basic_end: got valid=%b left=%0d expected 0 0", m_axis_tvalid, exp_q.size()); end
        checks++; if (hs_cnt != FB || last_cnt != 1) begin errors++; $display("FAIL basic_counts: got hs=%0d last=%0d expected 64 1", hs_cnt, last_cnt); end
        ack_valid = 1'b1;
        ack_bit = model_bit;
        tick;
        ack_valid = 1'b0;
        checks++; if (send_done !== 1'b1 || current_bit !== 1'b1) begin errors++; $display("FAIL basic_ack: got done=%b bit=%b expected 1 1", send_done, current_bit); end
        checks++; if (busy !== 1'b0 || send_ready !== 1'b1) begin errors++; $display("FAIL basic_idle: got busy=%b ready=%b expected 0 1", busy, send_ready); end
`ifdef ABP_SENDER_STATS_EN
        checks++; if (retx_count !== 16'h0000) begin errors++; $display("FAIL basic_retx: got %h expected 0000", retx_count); end
`endif
        model_bit = 1'b1;
        tick;
        checks++; if (send_done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", send_done); end
    endtask

    task automatic test_backpressure;
        hs_cnt = 0;
        last_cnt = 0;
        m_axis_tready = 1'b0;
        start_send(64'hDEAD_BEEF_CAFE_F00D);
        for (int i = 0; i < 400 && hs_cnt < FB; i++) begin
            m_axis_tready = ~m_axis_tready;
            ack_valid = (i == 10);
            ack_bit = model_bit;
            tick;
        end
        ack_valid = 1'b0;
        m_axis_tready = 1'b1;
        checks++; if (hs_cnt != FB || last_cnt != 1) begin errors++; $display("FAIL bp_counts: got hs=%0d last=%0d expected 64 1", hs_cnt, last_cnt); end
        checks++; if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL bp_end: got valid=%b left=%0d expected 0 0", m_axis_tvalid, exp_q.size()); end
        checks++; if (busy !== 1'b1 || current_bit !== model_bit) begin errors++; $display("FAIL bp_ack_in_send: got busy=%b bit=%b expected 1 %b", busy, current_bit, model_bit); end
        ack_valid = 1'b1;
        ack_bit = model_bit;
        tick;
        ack_valid = 1'b0;
        checks++; if (send_done !== 1'b1 || current_bit !== 1'b0) begin errors++; $display("FAIL bp_ack: got done=%b bit=%b expected 1 0", send_done, current_bit); end
        model_bit = 1'b0;
    endtask

    task automatic test_timeout;
        logic stayed;
        start_send(64'h1122_3344_5566_7788);
        repeat (FB) tick;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL to_frame_end: got %b expected 0", m_axis_tvalid); end
        push_frame(64'h1122_3344_5566_7788, model_bit);
        stayed = 1'b1;
        repeat (TO - 1) begin
            tick;
            if (m_axis_tvalid !== 1'b0) stayed = 1'b0;
        end
        checks++; if (stayed !== 1'b1) begin errors++; $display("FAIL to_early: got early retransmit expected none before 16 cycles"); end
        tick;
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h88) begin errors++; $display("FAIL to_restart: got valid=%b data=%h expected 1 88", m_axis_tvalid, m_axis_tdata); end
`ifdef ABP_SENDER_STATS_EN
        checks++; if (retx_count !== 16'h0001) begin errors++; $display("FAIL to_retx: got %h expected 0001", retx_count); end
`endif
        repeat (FB) tick;
        checks++; if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL to_resend_end: got valid=%b left=%0d expected 0 0", m_axis_tvalid, exp_q.size()); end
        ack_valid = 1'b1;
        ack_bit = model_bit;
        tick;
        ack_valid = 1'b0;
        checks++; if (send_done !== 1'b1 || current_bit !== 1'b1) begin errors++; $display("FAIL to_ack: got done=%b bit=%b expected 1 1", send_done, current_bit); end
`ifdef ABP_SENDER_STATS_EN
        checks++; if (retx_count !== 16'h0001) begin errors++; $display("FAIL to_retx_done: got %h expected 0001", retx_count); end
        tick;
        checks++; if (retx_count !== 16'h0000) begin errors++; $display("FAIL to_retx_clear: got %h expected 0000", retx_count); end
`endif
        model_bit = 1'b1;
    endtask

    task automatic test_stale_ack;
        logic stayed;
        start_send(64'hA5A5_5A5A_0F0F_F0F1);
        repeat (FB) tick;
        push_frame(64'hA5A5_5A5A_0F0F_F0F1, model_bit);
        ack_valid = 1'b1;
        ack_bit = ~model_bit;
        tick;
        ack_valid = 1'b0;
        stayed = (m_axis_tvalid === 1'b0) && (send_done === 1'b0);
        repeat (TO - 2) begin
            tick;
            if (m_axis_tvalid !== 1'b0 || send_done !== 1'b0) stayed = 1'b0;
        end
        checks++; if (stayed !== 1'b1) begin errors++; $display("FAIL stale_quiet: got activity expected stale ACK ignored"); end
        tick;
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hF1 || current_bit !== 1'b1) begin errors++; $display("FAIL stale_restart: got valid=%b data=%h bit=%b expected 1 f1 1", m_axis_tvalid, m_axis_tdata, current_bit); end
        repeat (FB) tick;
        ack_valid = 1'b1;
        ack_bit = model_bit;
        tick;
        ack_valid = 1'b0;
        checks++; if (send_done !== 1'b1 || current_bit !== 1'b0) begin errors++; $display("FAIL stale_ack: got done=%b bit=%b expected 1 0", send_done, current_bit); end
        model_bit = 1'b0;
    endtask

    task automatic test_collision;
        start_send(64'h0000_0000_0000_0042);
        repeat (FB) tick;
        repeat (TO - 1) tick;
        ack_valid = 1'b1;
        ack_bit = model_bit;
        tick;
        ack_valid = 1'b0;
        checks++; if (send_done !== 1'b1 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL coll_ack: got done=%b valid=%b expected 1 0", send_done, m_axis_tvalid); end
        checks++; if (busy !== 1'b0 || send_ready !== 1'b1 || current_bit !== 1'b1) begin errors++; $display("FAIL coll_idle: got busy=%b ready=%b bit=%b expected 0 1 1", busy, send_ready, current_bit); end
`ifdef ABP_SENDER_STATS_EN
        checks++; if (retx_count !== 16'h0000) begin errors++; $display("FAIL coll_retx: got %h expected 0000", retx_count); end
`endif
        model_bit = 1'b1;
        repeat (3) tick;
        checks++; if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL coll_noretx: got valid=%b left=%0d expected 0 0", m_axis_tvalid, exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        hs_cnt = 0;
        last_cnt = 0;
        start_send(64'hFEDC_BA98_7654_3210);
        repeat (21) tick;
        areset = 1'b1;
        tick;
        checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || current_bit !== 1'b0) begin errors++; $display("FAIL mid_reset: got valid=%b busy=%b bit=%b expected 0 0 0", m_axis_tvalid, busy, current_bit); end
        checks++; if (hs_cnt != 21 || last_cnt != 0 || exp_q.size() != FB - 21) begin errors++; $display("FAIL mid_counts: got hs=%0d last=%0d left=%0d expected 21 0 43", hs_cnt, last_cnt, exp_q.size()); end
        exp_q.delete();
        areset = 1'b0;
        model_bit = 1'b0;
        checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_low: got %b expected 0", send_ready); end
        tick;
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", send_ready); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] v;
        for (int n = 0; n < 2; n++) begin
            v = {$urandom, $urandom};
            start_send(v);
            checks++; if (m_axis_tdata !== v[7:0]) begin errors++; $display("FAIL b2b_first%0d: got %h expected %h", n, m_axis_tdata, v[7:0]); end
            repeat (FB) tick;
            ack_valid = 1'b1;
            ack_bit = model_bit;
            tick;
            ack_valid = 1'b0;
            checks++; if (send_done !== 1'b1 || current_bit !== ~model_bit || send_ready !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got done=%b bit=%b ready=%b expected 1 %b 1", n, send_done, current_bit, send_ready, ~model_bit); end
            model_bit = ~model_bit;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        areset = 1'b1;
        send_valid = 1'b0;
        send_value = 64'h0;
        m_axis_tready = 1'b1;
        ack_valid = 1'b0;
        ack_bit = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_timeout;
        test_stale_ack;
        test_collision;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
